// File: rtl/acf_calculator.sv
// acf_calculator: autocorrelation lags 0..ORDER of each BLOCK_SIZE-sample block, streamed as IEEE-754 singles, lag 0 first.
// Latency: last sample accepted at edge T -> lag 0 valid after edge T+3, lag ORDER (with oDone) after edge T+3+ORDER.
// Backpressure: none; one lag per enabled cycle, iEnable low freezes every register including the outputs.
// Ports: iClock / iReset_n (asynchronous, active-low), iEnable (global advance),
//        iSample / iValid (signed sample stream), oACF / oLag / oValid / oDone (lag stream).
// Build option: define ACF_ROUND_EN for round-to-nearest-even conversion; otherwise the magnitude is truncated.
module acf_calculator #(
   parameter int ORDER      = 12,
   parameter int BLOCK_SIZE = 4096,
   parameter int SAMPLE_W   = 16,
   parameter int ACC_W      = 48
) (
   input  logic                       iClock,
   input  logic                       iReset_n,
   input  logic                       iEnable,
   input  logic signed [SAMPLE_W-1:0] iSample,
   input  logic                       iValid,
   output logic [31:0]                oACF,
   output logic [3:0]                 oLag,
   output logic                       oValid,
   output logic                       oDone
);
   localparam int                CNT_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int                PROD_W   = 2 * SAMPLE_W;
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BLOCK_SIZE - 1);
   localparam logic [3:0]        LAST_LAG = 4'(ORDER);
   localparam logic [ACC_W-1:0]  ONE      = ACC_W'(1);

   // ---------------- stage 0: sample acceptance and delay line ----------------
   // tap[0] = x[n], tap[l] = x[n-l]
   logic signed [SAMPLE_W-1:0] tap [0:ORDER];
   logic [CNT_W-1:0]           smp_cnt;
   logic                       s0_vld, s0_last, blk_wrap;

   // The delay line must read zero for the first ORDER samples of a block. The
   // last sample's taps are still needed by the multiplier on the next edge, so
   // the clear is applied as the next block's first sample shifts in.
   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         for (int k = 0; k <= ORDER; k++) tap[k] <= '0;
         smp_cnt  <= '0;
         s0_vld   <= 1'b0;
         s0_last  <= 1'b0;
         blk_wrap <= 1'b0;
      end else if (iEnable) begin
         s0_vld  <= iValid;
         s0_last <= iValid && (smp_cnt == LAST_IDX);
         if (iValid) begin
            tap[0] <= iSample;
            for (int k = 1; k <= ORDER; k++) tap[k] <= blk_wrap ? '0 : tap[k-1];
            blk_wrap <= (smp_cnt == LAST_IDX);
            smp_cnt  <= (smp_cnt == LAST_IDX) ? '0 : smp_cnt + CNT_W'(1);
         end
      end
   end

   // ---------------- stage 1: parallel products ----------------
   logic signed [PROD_W-1:0] mul  [0:ORDER];
   logic signed [PROD_W-1:0] prod [0:ORDER];
   logic                     s1_last;

   always_comb begin
      for (int l = 0; l <= ORDER; l++) mul[l] = tap[0] * tap[l];
   end

   // Bubbles (no sample accepted) contribute a zero product.
   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         for (int l = 0; l <= ORDER; l++) prod[l] <= '0;
         s1_last <= 1'b0;
      end else if (iEnable) begin
         for (int l = 0; l <= ORDER; l++) prod[l] <= s0_vld ? mul[l] : '0;
         s1_last <= s0_vld && s0_last;
      end
   end

   // ---------------- stage 2: accumulate, hand block to output bank ----------------
   logic signed [ACC_W-1:0] acc  [0:ORDER];
   logic signed [ACC_W-1:0] bank [0:ORDER];
   logic signed [ACC_W-1:0] sum  [0:ORDER];

   always_comb begin
      for (int l = 0; l <= ORDER; l++)
         sum[l] = acc[l] + {{(ACC_W-PROD_W){prod[l][PROD_W-1]}}, prod[l]};
   end

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         for (int l = 0; l <= ORDER; l++) begin
            acc[l]  <= '0;
            bank[l] <= '0;
         end
      end else if (iEnable) begin
         for (int l = 0; l <= ORDER; l++) begin
            if (s1_last) begin
               bank[l] <= sum[l];
               acc[l]  <= '0;
            end else begin
               acc[l]  <= sum[l];
            end
         end
      end
   end

   // ---------------- integer to IEEE-754 single ----------------
   function automatic logic [31:0] to_float(input logic signed [ACC_W-1:0] v);
      logic [ACC_W-1:0] mag;
      logic [7:0]       exp_f;
      logic [22:0]      mant;
      int               msb;
`ifdef ACF_ROUND_EN
      logic             grd, stk;
`endif
      mag = v[ACC_W-1] ? -v : v;
      msb = 0;
      for (int i = 0; i < ACC_W; i++) if (mag[i]) msb = i;
      // Align the leading one to bit 23; the hidden bit falls off the 23-bit cast.
      if (msb >= 23) mant = 23'(mag >> (msb - 23));
      else           mant = 23'(mag << (23 - msb));
      exp_f = 8'(127 + msb);
`ifdef ACF_ROUND_EN
      if (msb >= 24) begin
         grd = mag[msb - 24];
         stk = |(mag & ((ONE << (msb - 24)) - ONE));
         if (grd && (stk || mant[0])) begin
            if (&mant) begin
               mant  = '0;
               exp_f = exp_f + 8'd1;
            end else begin
               mant  = mant + 23'd1;
            end
         end
      end
`endif
      if (mag == '0) to_float = 32'h0000_0000;
      else           to_float = {v[ACC_W-1], exp_f, mant};
   endfunction

   // ---------------- drain state machine ----------------
   typedef enum logic {S_IDLE, S_DRAIN} state_t;
   state_t     state;
   logic [3:0] lag_cnt;

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         state   <= S_IDLE;
         lag_cnt <= '0;
         oACF    <= '0;
         oLag    <= '0;
         oValid  <= 1'b0;
         oDone   <= 1'b0;
      end else if (iEnable) begin
         case (state)
            S_IDLE: begin
               oValid <= 1'b0;
               oDone  <= 1'b0;
               // bank is loaded on this same edge; first lag registers next edge
               if (s1_last) begin
                  state   <= S_DRAIN;
                  lag_cnt <= '0;
               end
            end
            S_DRAIN: begin
               oACF   <= to_float(bank[lag_cnt]);
               oLag   <= lag_cnt;
               oValid <= 1'b1;
               oDone  <= (lag_cnt == LAST_LAG);
               if (lag_cnt == LAST_LAG) state <= S_IDLE;
               else                     lag_cnt <= lag_cnt + 4'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_acf_calculator.sv
`timescale 1ns/1ps
module tb_acf_calculator;
   localparam int ORDER = 12;
   localparam int BS    = 16;
   localparam int SW    = 16;
   localparam int AW    = 48;

   logic                 iClock   = 1'b0;
   logic                 iReset_n = 1'b0;
   logic                 iEnable  = 1'b0;
   logic                 iValid   = 1'b0;
   logic signed [SW-1:0] iSample  = '0;
   logic [31:0]          oACF;
   logic [3:0]           oLag;
   logic                 oValid, oDone;

   acf_calculator #(.ORDER(ORDER), .BLOCK_SIZE(BS), .SAMPLE_W(SW), .ACC_W(AW)) dut (
      .iClock(iClock), .iReset_n(iReset_n), .iEnable(iEnable), .iSample(iSample),
      .iValid(iValid), .oACF(oACF), .oLag(oLag), .oValid(oValid), .oDone(oDone));

   always #5 iClock = ~iClock;

   typedef struct {
      logic [31:0] acf;
      logic [3:0]  lag;
      logic        done;
      int          cyc;   // expected cycle of appearance, -1 = not checked
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   logic en_prev = 1'b0;
   int   blk [BS];

   always @(posedge iClock) begin
      cyc     <= cyc + 1;
      en_prev <= iEnable;
   end

   // Reference conversion via real arithmetic.
   function automatic logic [31:0] to_f32(input longint v);
      real  m, f, fl;
      int   e;
      logic s;
      if (v == 0) return 32'h0;
      s = (v < 0);
      m = real'(s ? -v : v);
      e = 0;
      while (m >= 2.0) begin
         m = m / 2.0;
         e++;
      end
      f  = (m - 1.0) * 8388608.0;
      fl = $floor(f);
`ifdef ACF_ROUND_EN
      if ((f - fl) > 0.5 || ((f - fl) == 0.5 && (longint'(fl) % 2 == 1))) fl = fl + 1.0;
      if (fl >= 8388608.0) begin
         fl = 0.0;
         e++;
      end
`endif
      return {s, 8'(127 + e), 23'(longint'(fl))};
   endfunction

   task automatic push_expected(input int last_edge);
      for (int l = 0; l <= ORDER; l++) begin
         longint s;
         exp_t   x;
         s = 0;
         for (int n = l; n < BS; n++) s += longint'(blk[n]) * longint'(blk[n-l]);
         x.acf  = to_f32(s);
         x.lag  = 4'(l);
         x.done = (l == ORDER);
         x.cyc  = (last_edge < 0) ? -1 : last_edge + 3 + l;
         exp_q.push_back(x);
      end
   endtask

   // Drives blk[] as one block; leaves iValid high after the last sample.
   task automatic send_block(input bit gaps);
      int last_edge;
      last_edge = -1;
      for (int n = 0; n < BS; n++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge iClock);
               iEnable = 1'($urandom_range(0, 1));
               iValid  = iEnable ? 1'b0 : 1'($urandom_range(0, 1));
               iSample = SW'($urandom);
            end
         end
         @(negedge iClock);
         iEnable = 1'b1;
         iValid  = 1'b1;
         iSample = SW'(blk[n]);
         if (n == BS - 1 && !gaps) last_edge = cyc + 1;
      end
      push_expected(last_edge);
   endtask

   task automatic go_idle();
      @(negedge iClock);
      iValid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge iClock);
      repeat (3) @(negedge iClock);
   endtask

   // Scoreboard: every enabled-edge output is popped against the queue.
   always @(negedge iClock) begin
      exp_t e;
      if (iReset_n === 1'b1 && en_prev === 1'b1 && oValid === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: lag=%0d acf=%h at cycle %0d, required no output", oLag, oACF, cyc);
         end else begin
            e = exp_q.pop_front();
            if ({oACF, oLag, oDone} !== {e.acf, e.lag, e.done}) begin
               n_bad++;
               $display("FAIL lag_value: got acf=%h lag=%0d done=%b, required acf=%h lag=%0d done=%b",
                        oACF, oLag, oDone, e.acf, e.lag, e.done);
            end
            if (e.cyc >= 0) begin
               n_cmp++;
               if (cyc !== e.cyc) begin
                  n_bad++;
                  $display("FAIL latency: lag %0d appeared at cycle %0d, required %0d", e.lag, cyc, e.cyc);
               end
            end
         end
      end
   end

   task automatic test_reset();
      iReset_n = 1'b0;
      iEnable  = 1'b1;
      iValid   = 1'b0;
      repeat (3) @(negedge iClock);
      n_cmp++; if (oACF !== 32'h0)  begin n_bad++; $display("FAIL reset_acf: got %h, required 0", oACF); end
      n_cmp++; if (oLag !== 4'h0)   begin n_bad++; $display("FAIL reset_lag: got %0d, required 0", oLag); end
      n_cmp++; if (oValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", oValid); end
      n_cmp++; if (oDone !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b, required 0", oDone); end
      iReset_n = 1'b1;
      repeat (2) @(negedge iClock);
   endtask

   task automatic test_pattern(input int kind);
      for (int n = 0; n < BS; n++) begin
         case (kind)
            0:       blk[n] = 1;                                  // all ones
            1:       blk[n] = (n == 0) ? 1000 : 0;                // impulse
            2:       blk[n] = (n % 2 == 0) ? 1 : -1;              // alternating
            3:       blk[n] = (n == 0) ? 4096 : ((n < 4) ? 1 : 0);// rounding case
            default: blk[n] = int'($urandom_range(0, 65535)) - 32768;
         endcase
      end
      send_block(1'b0);
      go_idle();
      wait_drain();
      n_cmp++;
      if (exp_q.size() !== 0 || oValid !== 1'b0) begin
         n_bad++;
         $display("FAIL pattern%0d_drain: %0d lags outstanding, oValid=%b, required 0 and 0", kind, exp_q.size(), oValid);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < BS; n++) blk[n] = 1;
      send_block(1'b0);
      for (int n = 0; n < BS; n++) blk[n] = 0;
      send_block(1'b0);
      for (int n = 0; n < BS; n++) blk[n] = int'($urandom_range(0, 65535)) - 32768;
      send_block(1'b0);
      go_idle();
      wait_drain();
      n_cmp++;
      if (exp_q.size() !== 0 || oValid !== 1'b0) begin
         n_bad++;
         $display("FAIL back_to_back_drain: %0d lags outstanding, oValid=%b, required 0 and 0", exp_q.size(), oValid);
      end
   endtask

   task automatic test_gaps();
      for (int n = 0; n < BS; n++) blk[n] = int'($urandom_range(0, 2000)) - 1000;
      send_block(1'b1);
      for (int i = 0; i < 30; i++) begin
         @(negedge iClock);
         iValid  = 1'b0;
         iEnable = 1'($urandom_range(0, 1));
      end
      @(negedge iClock);
      iEnable = 1'b1;
      wait_drain();
      n_cmp++;
      if (exp_q.size() !== 0 || oValid !== 1'b0) begin
         n_bad++;
         $display("FAIL gaps_drain: %0d lags outstanding, oValid=%b, required 0 and 0", exp_q.size(), oValid);
      end
   endtask

   task automatic test_reset_mid_block();
      for (int n = 0; n < 7; n++) begin
         @(negedge iClock);
         iEnable = 1'b1;
         iValid  = 1'b1;
         iSample = SW'(5);
      end
      @(negedge iClock);
      iValid   = 1'b0;
      iReset_n = 1'b0;
      @(negedge iClock);
      n_cmp++;
      if (oValid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b, required 0", oValid); end
      iReset_n = 1'b1;
      for (int n = 0; n < BS; n++) blk[n] = 1;
      send_block(1'b0);
      go_idle();
      wait_drain();
      n_cmp++;
      if (exp_q.size() !== 0 || oValid !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_drain: %0d lags outstanding, oValid=%b, required 0 and 0", exp_q.size(), oValid);
      end
   endtask

   initial begin
      test_reset();
      test_pattern(0);
      test_pattern(1);
      test_pattern(2);
      test_pattern(3);
      test_pattern(4);
      test_back_to_back();
      test_gaps();
      test_reset_mid_block();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule
